// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inta_sequencer
// Description : 8259-style interrupt-acknowledge sequencer. It synchronizes the
//               CPU INTAn strobe and walks the two-pulse acknowledge cycle.
//               Along the way it issues ISR/IRR update pulses, drives the
//               cascade bus (master) or matches the cascade ID (slave), and
//               puts the vector byte on the data bus during the second pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module inta_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTAn,
  input  logic       int_req,
  input  logic [2:0] ir_id,
  input  logic       SPENn,
  input  logic [7:0] slave_mask,
  input  logic [2:0] slave_id,
  input  logic [4:0] vector_base,
  input  logic [2:0] cas_in,
  output logic       INT,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] isr_set,
  output logic [7:0] irr_clr,
  output logic       ack_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_ACK1   = 3'd2,
    S_GAP    = 3'd3,
    S_ACK2   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SYNC_STAGES-1:0] r_inta_sync;
  logic                   r_inta_prev;
  logic                   w_inta_s;
  logic                   w_fall;
  logic                   w_rise;
  logic                   w_take;
  logic [2:0]             w_lvl_new;
  logic [2:0]             r_lvl;
  logic                   r_spurious;
  logic                   r_cascaded;
  logic                   r_master;
  logic [2:0]             r_slave_id;
  logic                   r_match;
  logic                   r_ack1_first;
  logic                   w_cas_phase;
  logic                   w_owner;

  // INTAn is asynchronous; the synchronizer idles high (strobe inactive).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inta_sync <= '1;
      r_inta_prev <= 1'b1;
    end else begin
      r_inta_sync <= {r_inta_sync[SYNC_STAGES-2:0], INTAn};
      r_inta_prev <= w_inta_s;
    end
  end

  assign w_inta_s  = r_inta_sync[SYNC_STAGES-1];
  assign w_fall    = r_inta_prev & ~w_inta_s;
  assign w_rise    = ~r_inta_prev & w_inta_s;
  assign w_take    = (r_state == S_ARMED) && w_fall;
  // A request that vanished by the first strobe is answered as level 7.
  assign w_lvl_new = int_req ? ir_id : 3'd7;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; the strobe fall wins over a simultaneous int_req drop.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (int_req) w_state_next = S_ARMED;
      S_ARMED: begin
        if (w_fall)        w_state_next = S_ACK1;
        else if (!int_req) w_state_next = S_IDLE;
      end
      S_ACK1:   if (w_rise) w_state_next = S_GAP;
      S_GAP:    if (w_fall) w_state_next = S_ACK2;
      S_ACK2:   if (w_rise) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Sequence context: level, mode and cascade info frozen at ACK1 entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl        <= 3'd0;
      r_spurious   <= 1'b0;
      r_cascaded   <= 1'b0;
      r_master     <= 1'b0;
      r_slave_id   <= 3'd0;
      r_match      <= 1'b0;
      r_ack1_first <= 1'b0;
    end else begin
      r_ack1_first <= w_take;
      if (w_take) begin
        r_lvl      <= w_lvl_new;
        r_spurious <= ~int_req;
        r_master   <= SPENn;
        r_cascaded <= SPENn & slave_mask[w_lvl_new];
        r_slave_id <= slave_id;
        r_match    <= 1'b0;
      end
      if ((r_state == S_ACK1) && w_rise) begin
        r_match <= (cas_in == r_slave_id);
      end
    end
  end

  assign w_cas_phase = (r_state == S_ACK1) || (r_state == S_GAP) ||
                       (r_state == S_ACK2) || (r_state == S_FINISH);
  assign w_owner     = (r_state == S_ACK2) &&
                       ((r_master && !r_cascaded) || (!r_master && r_match));

  assign INT      = (r_state == S_ARMED) || (r_state == S_ACK1) || (r_state == S_GAP);
  assign cas_oe   = w_cas_phase && r_master && r_cascaded;
  assign cas_out  = cas_oe ? r_lvl : 3'd0;
  assign data_oe  = w_owner;
  assign data_out = w_owner ? {vector_base, r_lvl} : 8'h00;
  assign isr_set  = (r_ack1_first && !r_spurious) ? (8'd1 << r_lvl) : 8'd0;
  assign irr_clr  = isr_set;
  assign ack_done = (r_state == S_FINISH);

endmodule
`default_nettype wire

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, INTAn synchronizer depth (2..3).
REQ-002 SHALL have ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- INTAn  input  1  CPU interrupt-acknowledge strobe, active-low, asynchronous to clk
- int_req  input  1  priority resolver reports an unmasked request
- ir_id  input  3  highest-priority pending IR level
- SPENn  input  1  1 = master, 0 = slave
- slave_mask  input  8  master ICW3: IR levels with a slave attached
- slave_id  input  3  slave ICW3: own cascade ID
- vector_base  input  5  ICW2 bits T7..T3
- cas_in  input  3  sampled cascade lines
- INT  output  1  interrupt request to CPU
- cas_out  output  3  cascade ID driven by master
- cas_oe  output  1  cascade driver enable
- data_out  output  8  vector byte
- data_oe  output  1  data bus driver enable
- isr_set  output  8  one-hot ISR set pulse, 1 cycle
- irr_clr  output  8  one-hot IRR clear pulse, 1 cycle
- ack_done  output  1  acknowledge sequence complete pulse, 1 cycle

Function
REQ-003 SHALL synchronize INTAn through SYNC_STAGES flops; "fall" and "rise" are single-cycle edge detects on the synchronized signal.
REQ-004 SHALL implement states IDLE, ARMED, ACK1, GAP, ACK2, FINISH.
REQ-005 IDLE -> ARMED when int_req=1 (master) or int_req=1 with SPENn=0 (slave); INT=1 in ARMED, ACK1 and GAP, else 0.
REQ-006 ARMED -> IDLE when int_req drops before a fall; no pulses are issued.
REQ-007 ARMED -> ACK1 on fall; in the same cycle, latch lvl=ir_id if int_req=1, else latch lvl=7 and set the spurious flag.
REQ-008 On entry to ACK1, isr_set[lvl] and irr_clr[lvl] SHALL pulse for exactly 1 cycle, suppressed when spurious.
REQ-009 Master: if slave_mask[lvl]=1, cascaded=1; cas_out=lvl and cas_oe=1 from ACK1 entry until FINISH exit; otherwise cas_oe=0 and cas_out=000.
REQ-010 Slave: cas_oe SHALL stay 0; on the rise ending ACK1, sample cas_in; match=1 iff cas_in==slave_id.
REQ-011 ACK1 -> GAP on rise; GAP -> ACK2 on the next fall.
REQ-012 Vector owner in ACK2: master with cascaded=0, or slave with match=1; no other case owns the vector.
REQ-013 The owner SHALL drive data_oe=1 and data_out={vector_base, lvl} for all of ACK2; when not owner, data_oe=0 and data_out=8'h00.
REQ-014 ACK2 -> FINISH on rise; FINISH pulses ack_done for 1 cycle, then returns to IDLE.
REQ-015 A slave with match=0 SHALL still complete the sequence, but its isr_set is not withdrawn.
REQ-016 Simultaneous events: a fall in FINISH SHALL be ignored; int_req changes after ACK1 entry SHALL NOT alter lvl.
REQ-017 Max latency is SYNC_STAGES+1 clk from an INTAn edge to the state change and output update.
REQ-018 SPENn, slave_mask and slave_id SHALL be treated as static during a sequence; they are sampled only at the ARMED->ACK1 transition.

Reset
REQ-019 rst_n=0 SHALL immediately force state=IDLE, synchronizer flops=1, and lvl, spurious, cascaded and match to 0.
REQ-020 During reset all outputs SHALL be 0, independent of clk.
REQ-021 Reset asserted mid-sequence (any state) SHALL release cas_oe and data_oe in the same instant; no pending pulses SHALL be issued after release.

Verification
REQ-022 Master, slave_mask=0, vector_base=5'b01000, ir_id=3, int_req=1, two INTA pulses -> INT=1, then isr_set=irr_clr=8'h08 pulse, data_out=8'h43 with data_oe=1 during 2nd pulse, then ack_done.
REQ-023 Master, slave_mask=8'h04, ir_id=2 -> cas_out=3'b010 with cas_oe=1 from 1st pulse through FINISH, and data_oe=0 throughout.
REQ-024 Slave, slave_id=2, cas_in=2 in 1st pulse, vector_base=5'b10000, ir_id=5 -> data_out=8'h85 during 2nd pulse; with cas_in=6 instead -> data_oe stays 0.
REQ-025 int_req drops at the same cycle as the synchronized fall -> spurious: no isr_set/irr_clr pulse, and data_out={vector_base,3'b111} in 2nd pulse.
REQ-026 rst_n pulsed low during ACK2 -> data_oe, cas_oe and INT go 0 asynchronously; after release the block returns to IDLE and no ack_done is issued.
